// File: rtl/fabric_config_loader.sv
// Streams a configuration frame into fabric storage, one registered write per data word,
// and enables the fabric only when the trailing XOR checksum matches the accumulated frame.
module fabric_config_loader #(
   parameter int unsigned NUM_WORDS = 33,
   parameter int unsigned ADDR_W    = 6,
   parameter int unsigned DATA_W    = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] cfg_addr,
   output logic [DATA_W-1:0] cfg_data,
   output logic              cfg_we,
   output logic              fabric_en,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StCheck,
      StDone,
      StError
   } state_e;

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_WORDS - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [ADDR_W-1:0]   cfg_addr_q, cfg_addr_d;
   logic [DATA_W-1:0]   cfg_data_q, cfg_data_d;
   logic                cfg_we_q, cfg_we_d;
   logic                fabric_en_q, fabric_en_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                accept;

   assign in_ready  = (state_q == StLoad) || (state_q == StCheck);
   assign busy      = in_ready;
   assign accept    = in_valid && in_ready;
   assign cfg_addr  = cfg_addr_q;
   assign cfg_data  = cfg_data_q;
   assign cfg_we    = cfg_we_q;
   assign fabric_en = fabric_en_q;
   assign done      = done_q;
   assign error     = error_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      cfg_addr_d  = cfg_addr_q;
      cfg_data_d  = cfg_data_q;
      cfg_we_d    = 1'b0;
      fabric_en_d = fabric_en_q;
      done_d      = done_q;
      error_d     = error_q;

      unique case (state_q)
         StIdle, StDone, StError: begin
            if (start) begin
               state_d     = StLoad;
               cnt_d       = '0;
               acc_d       = '0;
               done_d      = 1'b0;
               error_d     = 1'b0;
               fabric_en_d = 1'b0;
            end
         end
         StLoad: begin
            if (accept) begin
               acc_d      = acc_q ^ in_data;
               cfg_we_d   = 1'b1;
               cfg_addr_d = cnt_q;
               cfg_data_d = in_data;
               // Counter parks on the last index so it never points past the frame.
               if (cnt_q == LastIdx) begin
                  state_d = StCheck;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StCheck: begin
            if (accept) begin
               if (in_data == acc_q) begin
                  state_d     = StDone;
                  done_d      = 1'b1;
                  fabric_en_d = 1'b1;
               end else begin
                  state_d     = StError;
                  error_d     = 1'b1;
                  fabric_en_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         acc_q       <= '0;
         cfg_addr_q  <= '0;
         cfg_data_q  <= '0;
         cfg_we_q    <= 1'b0;
         fabric_en_q <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         cfg_addr_q  <= cfg_addr_d;
         cfg_data_q  <= cfg_data_d;
         cfg_we_q    <= cfg_we_d;
         fabric_en_q <= fabric_en_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed bench for fabric_config_loader: clean, corrupt, gapped, aborted and restarted frames.
module tb_fabric_config_loader;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        cfg_we;
   logic        fabric_en;
   logic        busy;
   logic        done;
   logic        error;

   int n_cmp = 0;
   int n_bad = 0;
   int wr_cnt = 0;

   always #5 clock = ~clock;

   fabric_config_loader #(
      .NUM_WORDS(33),
      .ADDR_W   (6),
      .DATA_W   (32)
   ) u_dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .cfg_we   (cfg_we),
      .fabric_en(fabric_en),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always @(negedge clock) begin
      if (cfg_we === 1'b1) wr_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] word_of(input int mode, input int idx);
      return (mode == 0) ? 32'(idx + 1) : 32'h0;
   endfunction

   task automatic send_word(input logic [31:0] d, input bit is_data, input int idx);
      check("in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      if (is_data) begin
         check("cfg_we", cfg_we, 1);
         check("cfg_addr", cfg_addr, idx);
         check("cfg_data", cfg_data, d);
      end else begin
         check("cks_no_we", cfg_we, 0);
      end
   endtask

   task automatic send_range(input int first, input int last, input int mode, input bit gaps);
      for (int i = first; i <= last; i++) begin
         send_word(word_of(mode, i), 1'b1, i);
         if (gaps) begin
            tick();
            check("gap_we", cfg_we, 0);
            check("gap_busy", busy, 1);
         end
      end
   endtask

   task automatic start_load();
      start = 1'b1;
      tick();
      start  = 1'b0;
      wr_cnt = 0;
      check("start_busy", busy, 1);
      check("start_fen", fabric_en, 0);
      check("start_done", done, 0);
      check("start_err", error, 0);
   endtask

   task automatic finish_frame(input logic [31:0] cks, input bit ok);
      send_word(cks, 1'b0, 0);
      tick();
      check("wr_count", wr_cnt, 33);
      check("done", done, ok);
      check("error", error, !ok);
      check("fabric_en", fabric_en, ok);
      check("idle_ready", in_ready, 0);
      check("idle_busy", busy, 0);
   endtask

   task automatic stray_valid();
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      check("stray_we", cfg_we, 0);
      check("stray_busy", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      tick();
      tick();
      check("reset_outs", {in_ready, cfg_addr, cfg_data, cfg_we, fabric_en, busy, done, error}, 0);
      reset_n = 1'b1;
      tick();
      stray_valid();

      // Clean frame: XOR of 1..33 is 1.
      start_load();
      send_range(0, 32, 0, 1'b0);
      finish_frame(32'h1, 1'b1);

      // Corrupt checksum, then a retry that passes.
      start_load();
      send_range(0, 32, 0, 1'b0);
      finish_frame(32'h0, 1'b0);
      start_load();
      send_range(0, 32, 0, 1'b0);
      finish_frame(32'h1, 1'b1);

      // Valid on alternate cycles only.
      start_load();
      send_range(0, 32, 0, 1'b1);
      finish_frame(32'h1, 1'b1);

      // Reset after ten accepts, then a full reload.
      start_load();
      send_range(0, 9, 0, 1'b0);
      reset_n = 1'b0;
      tick();
      check("abort_outs", {in_ready, cfg_addr, cfg_data, cfg_we, fabric_en, busy, done, error}, 0);
      reset_n = 1'b1;
      tick();
      check("abort_idle", busy, 0);
      start_load();
      send_range(0, 32, 0, 1'b0);
      finish_frame(32'h1, 1'b1);

      // Start mid-load is ignored.
      start_load();
      send_range(0, 5, 0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("midstart_busy", busy, 1);
      check("midstart_we", cfg_we, 0);
      send_range(6, 32, 0, 1'b0);
      finish_frame(32'h1, 1'b1);

      // Valid in DONE is ignored; start in DONE drops fabric_en; all-zero frame.
      stray_valid();
      check("done_hold", done, 1);
      start_load();
      send_range(0, 32, 1, 1'b0);
      finish_frame(32'h0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
